// File: rtl/io_pwm_led_if.sv
// rtl/io_pwm_led_if.sv - CPU store-to-IO bus bundle for io_pwm_led
interface io_pwm_led_if;
    logic [3:0]  st_we_io;
    logic [9:0]  st_adr_io;
    logic [31:0] st_data_io;

    modport master (
        output st_we_io,
        output st_adr_io,
        output st_data_io
    );

    modport slave (
        input st_we_io,
        input st_adr_io,
        input st_data_io
    );
endinterface

// File: rtl/io_pwm_led.sv
// rtl/io_pwm_led.sv - memory-mapped RGB PWM LED driver with shadowed duty and linear fade
module io_pwm_led #(
    parameter int CLKDIV   = 16,
    parameter int FADE_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    io_pwm_led_if.slave bus,
    output logic [2:0]  rgb_led
);
    localparam int PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(CLKDIV - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FADE_DIV - 1);
    localparam logic [9:0]    ADR_DUTY  = 10'h200;
    localparam logic [9:0]    ADR_CTRL  = 10'h201;

    logic [7:0]    tgt_r, tgt_g, tgt_b;
    logic [7:0]    cur_r, cur_g, cur_b;
    logic          en, fade, inv;
    logic [PW-1:0] pre;
    logic [7:0]    cnt;
    logic [FW-1:0] fcnt;

    logic          duty_wr, ctrl_wr, en_on, en_off;
    logic          tick, pbound, fade_step;
    logic [2:0]    raw;
    logic          unused_data;

    // Byte 3 of a DUTY store carries nothing.
    assign unused_data = &{1'b0, bus.st_data_io[31:24]};

    function automatic logic [7:0] step_toward(input logic [7:0] c, input logic [7:0] t);
        if (c < t)
            return c + 8'd1;
        else if (c > t)
            return c - 8'd1;
        else
            return c;
    endfunction

    // Write decode, period timing and comparator; en_on/en_off see the pre-write CTRL.
    always_comb begin
        duty_wr   = (|bus.st_we_io) && (bus.st_adr_io == ADR_DUTY);
        ctrl_wr   = bus.st_we_io[0] && (bus.st_adr_io == ADR_CTRL);
        en_on     = ctrl_wr && bus.st_data_io[0] && !en;
        en_off    = ctrl_wr && !bus.st_data_io[0] && en;
        tick      = en && (pre == PRE_LAST);
        pbound    = tick && (cnt == 8'hFF);
        fade_step = fade && (fcnt == FCNT_LAST);
        raw[2]    = en && (cnt < cur_r);
        raw[1]    = en && (cnt < cur_g);
        raw[0]    = en && (cnt < cur_b);
    end

    // Target and control registers, byte-enabled, visible one cycle after the store.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tgt_r <= 8'd0;
            tgt_g <= 8'd0;
            tgt_b <= 8'd0;
            en    <= 1'b0;
            fade  <= 1'b0;
            inv   <= 1'b0;
        end else begin
            if (duty_wr && bus.st_we_io[0]) tgt_r <= bus.st_data_io[7:0];
            if (duty_wr && bus.st_we_io[1]) tgt_g <= bus.st_data_io[15:8];
            if (duty_wr && bus.st_we_io[2]) tgt_b <= bus.st_data_io[23:16];
            if (ctrl_wr) begin
                en   <= bus.st_data_io[0];
                fade <= bus.st_data_io[1];
                inv  <= bus.st_data_io[2];
            end
        end
    end

    // Prescaler and PWM step counter; parked at zero while disabled so EN restarts a period.
    always_ff @(posedge clk) begin
        if (rst_n || en_off || !en) begin
            pre <= '0;
            cnt <= 8'd0;
        end else if (tick) begin
            pre <= '0;
            cnt <= cnt + 8'd1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Fade divider counts period boundaries while fading.
    always_ff @(posedge clk) begin
        if (rst_n || en_off) begin
            fcnt <= '0;
        end else if (pbound) begin
            if (!fade || fade_step)
                fcnt <= '0;
            else
                fcnt <= fcnt + 1'b1;
        end
    end

    // Comparator shadow registers: change only at a period boundary or an enabling CTRL write.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cur_r <= 8'd0;
            cur_g <= 8'd0;
            cur_b <= 8'd0;
        end else if (pbound) begin
            if (!fade) begin
                cur_r <= tgt_r;
                cur_g <= tgt_g;
                cur_b <= tgt_b;
            end else if (fade_step) begin
                cur_r <= step_toward(cur_r, tgt_r);
                cur_g <= step_toward(cur_g, tgt_g);
                cur_b <= step_toward(cur_b, tgt_b);
            end
        end else if (en_on && !bus.st_data_io[1]) begin
            cur_r <= tgt_r;
            cur_g <= tgt_g;
            cur_b <= tgt_b;
        end
    end

    // Registered outputs; a disabling write drops them on the very next cycle.
    always_ff @(posedge clk) begin
        if (rst_n || en_off)
            rgb_led <= 3'b000;
        else
            rgb_led <= raw ^ {3{inv & en}};
    end
endmodule

// File: tb/tb_io_pwm_led.sv
// tb/tb_io_pwm_led.sv - directed self-checking bench for io_pwm_led
module tb_io_pwm_led;
    localparam int C  = 4;
    localparam int FD = 4;
    localparam int P  = 256 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rgb_led;
    int         checks = 0;
    int         failures = 0;

    io_pwm_led_if bus ();

    io_pwm_led #(.CLKDIV(C), .FADE_DIV(FD)) dut (
        .clk     (clk),
        .rst_n   (rst),
        .bus     (bus),
        .rgb_led (rgb_led)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [9:0] adr, input logic [3:0] we, input logic [31:0] data);
        @(negedge clk);
        bus.st_adr_io  = adr;
        bus.st_we_io   = we;
        bus.st_data_io = data;
        @(negedge clk);
        bus.st_adr_io  = 10'd0;
        bus.st_we_io   = 4'd0;
        bus.st_data_io = 32'd0;
    endtask

    task automatic restart(input logic [31:0] ctrl);
        bus_write(10'h201, 4'b0001, 32'd0);
        bus_write(10'h201, 4'b0001, ctrl);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_period(input int wr_at, input logic [9:0] adr, input logic [3:0] we,
                              input logic [31:0] data, output int hr, output int hg, output int hb);
        hr = 0; hg = 0; hb = 0;
        for (int k = 0; k < P; k++) begin
            @(posedge clk);
            #1;
            hr += rgb_led[2] ? 1 : 0;
            hg += rgb_led[1] ? 1 : 0;
            hb += rgb_led[0] ? 1 : 0;
            if (k == wr_at) begin
                bus.st_adr_io  = adr;
                bus.st_we_io   = we;
                bus.st_data_io = data;
            end else if (k == wr_at + 1) begin
                bus.st_adr_io  = 10'd0;
                bus.st_we_io   = 4'd0;
                bus.st_data_io = 32'd0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rgb_led !== 3'b000) begin
            failures++;
            $display("FAIL reset_rgb got=%b exp=000", rgb_led);
        end
        checks++;
        if ({dut.tgt_r, dut.tgt_g, dut.tgt_b, dut.cur_r, dut.cur_g, dut.cur_b,
             dut.en, dut.fade, dut.inv, dut.cnt} !== 59'd0) begin
            failures++;
            $display("FAIL reset_regs tgt_r=%h cur_r=%h en=%b cnt=%0d exp=all zero",
                     dut.tgt_r, dut.cur_r, dut.en, dut.cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int hr, hg, hb;
        bus_write(10'h200, 4'b1111, 32'h0000_0080);
        bus_write(10'h201, 4'b0001, 32'h0000_0001);
        checks++;
        if (dut.cnt !== 8'd0 || dut.cur_r !== 8'h80) begin
            failures++;
            $display("FAIL basic_start cnt=%0d cur_r=%h exp cnt=0 cur_r=80", dut.cnt, dut.cur_r);
        end
        for (int p = 0; p < 2; p++) begin
            run_period(-10, 10'd0, 4'd0, 32'd0, hr, hg, hb);
            checks++;
            if (hr != 128 * C || hg != 0 || hb != 0) begin
                failures++;
                $display("FAIL basic_period%0d got r=%0d g=%0d b=%0d exp r=%0d g=0 b=0",
                         p, hr, hg, hb, 128 * C);
            end
        end
    endtask

    task automatic test_byte_enable();
        int hr, hg, hb;
        bus_write(10'h200, 4'b0010, 32'h00FF_40FF);
        checks++;
        if (dut.tgt_r !== 8'h80 || dut.tgt_g !== 8'h40 || dut.tgt_b !== 8'h00) begin
            failures++;
            $display("FAIL byte_en_tgt got r=%h g=%h b=%h exp r=80 g=40 b=00",
                     dut.tgt_r, dut.tgt_g, dut.tgt_b);
        end
        bus_write(10'h1FF, 4'b1111, 32'h00FF_FFFF);
        bus_write(10'h202, 4'b1111, 32'h0000_0000);
        checks++;
        if (dut.tgt_r !== 8'h80 || dut.tgt_g !== 8'h40 || dut.tgt_b !== 8'h00 || dut.en !== 1'b1) begin
            failures++;
            $display("FAIL other_addr got r=%h g=%h b=%h en=%b exp r=80 g=40 b=00 en=1",
                     dut.tgt_r, dut.tgt_g, dut.tgt_b, dut.en);
        end
        restart(32'h1);
        run_period(-10, 10'd0, 4'd0, 32'd0, hr, hg, hb);
        checks++;
        if (hr != 128 * C || hg != 64 * C || hb != 0) begin
            failures++;
            $display("FAIL byte_en_period got r=%0d g=%0d b=%0d exp r=%0d g=%0d b=0",
                     hr, hg, hb, 128 * C, 64 * C);
        end
    endtask

    task automatic test_mid_update();
        int hr, hg, hb;
        restart(32'h1);
        run_period(50 * C, 10'h200, 4'b0001, 32'h0000_0010, hr, hg, hb);
        checks++;
        if (hr != 128 * C || hg != 64 * C) begin
            failures++;
            $display("FAIL mid_cur_period got r=%0d g=%0d exp r=%0d g=%0d", hr, hg, 128 * C, 64 * C);
        end
        run_period(-10, 10'd0, 4'd0, 32'd0, hr, hg, hb);
        checks++;
        if (hr != 16 * C || hg != 64 * C) begin
            failures++;
            $display("FAIL mid_next_period got r=%0d g=%0d exp r=%0d g=%0d", hr, hg, 16 * C, 64 * C);
        end
    endtask

    task automatic test_extremes();
        int hr, hg, hb;
        bus_write(10'h200, 4'b0111, 32'h0000_FF00);
        restart(32'h1);
        run_period(-10, 10'd0, 4'd0, 32'd0, hr, hg, hb);
        checks++;
        if (hr != 0 || hg != 255 * C || hb != 0) begin
            failures++;
            $display("FAIL extremes got r=%0d g=%0d b=%0d exp r=0 g=%0d b=0", hr, hg, hb, 255 * C);
        end
        checks++;
        if (P - hg != C) begin
            failures++;
            $display("FAIL duty255_low got=%0d exp=%0d", P - hg, C);
        end
        restart(32'h5);
        for (int p = 0; p < 2; p++) begin
            run_period(-10, 10'd0, 4'd0, 32'd0, hr, hg, hb);
            checks++;
            if (hr != P || hg != C || hb != P) begin
                failures++;
                $display("FAIL inv_period%0d got r=%0d g=%0d b=%0d exp r=%0d g=%0d b=%0d",
                         p, hr, hg, hb, P, C, P);
            end
        end
    endtask

    task automatic test_fade();
        int hr, hg, hb;
        int mcur, mtgt, mfcnt;
        do_reset();
        bus_write(10'h200, 4'b0001, 32'h0000_0003);
        bus_write(10'h201, 4'b0001, 32'h0000_0003);
        mcur = 0; mtgt = 3; mfcnt = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 17)
                run_period(0, 10'h200, 4'b0001, 32'h0000_0001, hr, hg, hb);
            else
                run_period(-10, 10'd0, 4'd0, 32'd0, hr, hg, hb);
            checks++;
            if (hr != mcur * C || hg != 0 || hb != 0) begin
                failures++;
                $display("FAIL fade_period%0d got r=%0d g=%0d b=%0d exp r=%0d g=0 b=0",
                         k, hr, hg, hb, mcur * C);
            end
            if (k == 17) mtgt = 1;
            if (mfcnt == FD - 1) begin
                mfcnt = 0;
                if (mcur < mtgt) mcur++;
                else if (mcur > mtgt) mcur--;
            end else begin
                mfcnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus_write(10'h200, 4'b0001, 32'h0000_0080);
        bus_write(10'h201, 4'b0001, 32'h0000_0001);
        repeat (5) @(negedge clk);
        checks++;
        if (rgb_led !== 3'b100) begin
            failures++;
            $display("FAIL pre_reset_high got=%b exp=100", rgb_led);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rgb_led !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_rgb got=%b exp=000", rgb_led);
        end
        checks++;
        if ({dut.tgt_r, dut.cur_r, dut.en, dut.cnt, dut.pre} !== '0) begin
            failures++;
            $display("FAIL reset_mid_regs tgt_r=%h cur_r=%h en=%b cnt=%0d exp zero",
                     dut.tgt_r, dut.cur_r, dut.en, dut.cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (rgb_led !== 3'b000) begin
            failures++;
            $display("FAIL after_reset_rgb got=%b exp=000", rgb_led);
        end
    endtask

    task automatic test_disable();
        bus_write(10'h200, 4'b0001, 32'h0000_00C8);
        bus_write(10'h201, 4'b0001, 32'h0000_0001);
        repeat (20) @(negedge clk);
        checks++;
        if (rgb_led !== 3'b100) begin
            failures++;
            $display("FAIL pre_disable_high got=%b exp=100", rgb_led);
        end
        bus.st_adr_io  = 10'h201;
        bus.st_we_io   = 4'b0001;
        bus.st_data_io = 32'h0;
        @(posedge clk);
        #1;
        checks++;
        if (rgb_led !== 3'b000) begin
            failures++;
            $display("FAIL disable_rgb got=%b exp=000", rgb_led);
        end
        @(negedge clk);
        bus.st_adr_io  = 10'd0;
        bus.st_we_io   = 4'd0;
        checks++;
        if (dut.cnt !== 8'd0 || dut.pre !== '0 || dut.cur_r !== 8'hC8) begin
            failures++;
            $display("FAIL disable_state cnt=%0d pre=%0d cur_r=%h exp cnt=0 pre=0 cur_r=c8",
                     dut.cnt, dut.pre, dut.cur_r);
        end
        bus_write(10'h201, 4'b0001, 32'h0000_0004);
        repeat (30) @(negedge clk);
        checks++;
        if (rgb_led !== 3'b000) begin
            failures++;
            $display("FAIL inv_disabled_rgb got=%b exp=000", rgb_led);
        end
    endtask

    initial begin
        bus.st_adr_io  = 10'd0;
        bus.st_we_io   = 4'd0;
        bus.st_data_io = 32'd0;
        test_reset();
        test_basic();
        test_byte_enable();
        test_mid_update();
        test_extremes();
        test_fade();
        test_reset_mid();
        test_disable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/io_pwm_led.md
# io_pwm_led

Memory-mapped RGB LED PWM driver on the CPU store-to-IO bus (`st_we_io` / `st_adr_io` / `st_data_io`), alongside `io_led` in the FPGA top. The CPU writes per-channel 8-bit duty targets and a control word. The block generates glitch-free PWM on `rgb_led[2:0]`, with optional linear fading toward the target. It is write-only and never stalls the CPU.

## Interface
- `CLKDIV`, default 16: prescaler; one PWM step every `CLKDIV` clocks (≥2).
- `FADE_DIV`, default 4: in fade mode, `cur` moves one LSB every `FADE_DIV` PWM periods (≥1).
- `clk`  in  1  system clock (PLL `clk0_out`).
- `rst_n`  in  1  reset, synchronous, active-high (1 = reset); port name kept for top-level consistency.
- `st_we_io`  in  4  byte write enables for the current store; nonzero means a write this cycle.
- `st_adr_io`  in  10  word address [11:2].
- `st_data_io`  in  32  store data.
- `rgb_led`  out  3  {R,G,B} PWM outputs, registered, active-high.

## Operation
- **Register map** (word address `st_adr_io`):
  - `10'h200` DUTY:
    - byte0 → `tgt_r`
    - byte1 → `tgt_g`
    - byte2 → `tgt_b`
    - byte3 ignored
    - each byte is written only when its `st_we_io` bit is set
  - `10'h201` CTRL:
    - bit0 EN
    - bit1 FADE
    - bit2 INV (invert outputs)
    - written when `st_we_io[0]` = 1
  - All other addresses are ignored, leaving `io_led` space untouched.
- **Prescaler**: `pre` counts 0..`CLKDIV`-1 and wraps. `tick` = (`pre` == `CLKDIV`-1).
- **PWM counter**: `cnt[7:0]` increments on `tick` and wraps 255→0. `pbound` = `tick` & (`cnt` == 255), i.e. the period end.
- **Duty shadowing**:
  - `cur_{r,g,b}` drive the comparator and update only on `pbound`.
  - Targets written mid-period never change the current period.
  - FADE=0: on `pbound`, `cur` ← `tgt`.
  - FADE=1:
    - `fcnt` counts `pbound` events 0..`FADE_DIV`-1.
    - On `pbound` with `fcnt` == `FADE_DIV`-1, each `cur` steps ±1 toward its `tgt`. A channel with `cur` == `tgt` holds.
    - Saturating: no overshoot, no wrap.
- **Comparator**: `raw[ch]` = EN & (`cnt` < `cur[ch]`).
  - duty 0: always off.
  - duty 255: on 255 of 256 steps.
  - `rgb_led` ← `raw` ^ {3{INV & EN}}, registered.
  - EN=0 forces `rgb_led` = 0 regardless of INV.
- **EN edges**:
  - EN 1→0 forces outputs low on the next cycle. `pre`, `cnt` and `fcnt` are also cleared; `cur` is kept.
  - EN 0→1 restarts the period at `cnt` = 0.
  - While EN=0, `pre` and `cnt` hold at 0. Targets still load into `cur` by setting EN, which acts as a forced boundary: on a CTRL write with EN 0→1, `cur` ← `tgt` immediately when FADE=0. With FADE=1, `cur` is retained.
- **Simultaneous events**:
  - A DUTY write on the same cycle as `pbound`: `cur` loads the old `tgt`; the new `tgt` applies at the next boundary.
  - A CTRL write on the same cycle as `pbound`: the boundary uses the old CTRL.

## Timing
- **Reset** (`rst_n`=1 sampled at a `clk` edge) clears:
  - `rgb_led` = 3'b000
  - all `tgt`/`cur` = 0
  - CTRL = 0
  - `pre` = `cnt` = `fcnt` = 0
- Reset mid-period takes effect on the next edge with no partial pulse.
- Register write latency: `tgt`/CTRL are visible 1 cycle after the write cycle.
- Output latency: `rgb_led` reflects `cnt`/`cur` with a 1-cycle register delay.
- Period = 256×`CLKDIV` clocks (4096 at the default).
- High time per period = `cur`×`CLKDIV` clocks.
- FADE full swing 0→255 = 255×`FADE_DIV` periods.

## Test plan
- Reset, then DUTY=`32'h0000_0080`, CTRL=1 → R high exactly 128×16 = 2048 clocks of every 4096; G and B stay 0. Check `cnt` restarts at 0 on the EN write.
- Byte-enable: DUTY=`32'h00FF_40FF` with `st_we_io`=4'b0010 → only `tgt_g`=`8'h40`; R and B unchanged.
- Mid-period update: while R runs at 128, write R=16 at `cnt`=50 → current period keeps a 2048-clock high; the next period is 256 clocks high.
- Boundary extremes: duty 0 → never high; duty 255 → low exactly 16 clocks per period. INV=1 with duty 0 → constantly high.
- Fade: CTRL=3, `FADE_DIV`=4, R target 0→3 → `cur_r` = 1, 2, 3 after 4, 8 and 12 periods, then holds. Retarget to 1 → steps down to 1, never below.
- Reset and disable mid-operation: assert `rst_n`=1 during an R-high phase → `rgb_led`=0 the next cycle and all registers read back 0. Separately, EN 1→0 → outputs 0 the next cycle.
